// File: rtl/read_controller_pkg.sv
// Shared definitions for the word RAM controllers: geometry, address width,
// the reader FSM state encoding and the wrapping address increment.
package read_controller_pkg;

    localparam int unsigned S1_LENGTH = 3444;
    localparam int unsigned DATA_W    = 2048;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } rd_state_t;

    // Next word address, wrapping to 0 after len-1.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a,
                                                    input int unsigned len);
        return (32'(a) == len - 1) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/read_controller_p2s.sv
// Parallel-to-serial stage: holds the active word (and, with
// READ_CTRL_PREFETCH_EN, a shadow word), walks the byte index MSB byte
// first and drives the valid/ready byte stream.
module p2s #(
    parameter int unsigned DATA_W = read_controller_pkg::DATA_W,
    parameter int unsigned BYTE_W = read_controller_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
`ifdef READ_CTRL_PREFETCH_EN
    input  logic              shadow_load,
    input  logic              chain_en,
    output logic              chained,
`endif
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              word_done
);

    localparam int unsigned NBYTES = DATA_W / BYTE_W;
    localparam int unsigned IDX_W  = $clog2(NBYTES);

    logic [DATA_W-1:0] word_buf;
    logic [IDX_W-1:0]  byte_idx;
    logic              accept;
    logic              last;
`ifdef READ_CTRL_PREFETCH_EN
    logic [DATA_W-1:0] shadow_buf;
    logic              shadow_full;
`endif

    assign accept = m_valid && m_ready;
    assign last   = (byte_idx == IDX_W'(NBYTES - 1));
    assign m_data = word_buf[(NBYTES - 1 - 32'(byte_idx)) * BYTE_W +: BYTE_W];

    // Word load, byte advance on handshake, end-of-word pulse and shadow swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_buf  <= '0;
            byte_idx  <= '0;
            m_valid   <= 1'b0;
            word_done <= 1'b0;
`ifdef READ_CTRL_PREFETCH_EN
            shadow_buf  <= '0;
            shadow_full <= 1'b0;
            chained     <= 1'b0;
`endif
        end else begin
            word_done <= accept && last;
            if (load) begin
                word_buf <= load_data;
                byte_idx <= '0;
                m_valid  <= 1'b1;
            end else if (accept) begin
                if (last) begin
                    byte_idx <= '0;
`ifdef READ_CTRL_PREFETCH_EN
                    if (shadow_full && chain_en) begin
                        word_buf <= shadow_buf;
                        m_valid  <= 1'b1;
                    end else begin
                        m_valid <= 1'b0;
                    end
`else
                    m_valid <= 1'b0;
`endif
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
`ifdef READ_CTRL_PREFETCH_EN
            // An unused shadow word is dropped at the word boundary.
            chained <= accept && last && shadow_full && chain_en;
            if (shadow_load) begin
                shadow_buf  <= load_data;
                shadow_full <= 1'b1;
            end else if (accept && last) begin
                shadow_full <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/read_controller.sv
// Word reader: sequences RAM reads over 0..S1_LENGTH-1, tracks read latency
// and feeds the p2s stage. Define READ_CTRL_PREFETCH_EN to fetch the next
// word into a shadow buffer while the current one is shifting out.
module read_controller #(
    parameter int unsigned S1_LENGTH  = read_controller_pkg::S1_LENGTH,
    parameter int unsigned DATA_W     = read_controller_pkg::DATA_W,
    parameter int unsigned BYTE_W     = read_controller_pkg::BYTE_W,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               run,
    output logic                               rd_en,
    output logic [read_controller_pkg::ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]                  rd_data,
    output logic [BYTE_W-1:0]                  m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               word_done,
    output logic                               busy
);

    import read_controller_pkg::*;

    localparam int unsigned LAT_W = 4;

    rd_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              load;
`ifdef READ_CTRL_PREFETCH_EN
    logic [ADDR_W-1:0] nxt2;
    logic              bg_pend;
    logic              shadow_load;
    logic              chained;

    assign nxt2        = addr_next(nxt, S1_LENGTH);
    assign shadow_load = bg_pend && (lat_cnt == LAT_W'(RD_LATENCY));
`endif

    // lat_cnt is 0 in the rd_en cycle, so data is due when it equals RD_LATENCY.
    assign nxt  = addr_next(addr, S1_LENGTH);
    assign load = (state == WAIT) && (lat_cnt == LAT_W'(RD_LATENCY));

    p2s #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_p2s (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_data   (rd_data),
`ifdef READ_CTRL_PREFETCH_EN
        .shadow_load (shadow_load),
        .chain_en    (run),
        .chained     (chained),
`endif
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .word_done   (word_done)
    );

    // Read sequencing FSM with address and latency counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            lat_cnt <= '0;
            busy    <= 1'b0;
`ifdef READ_CTRL_PREFETCH_EN
            bg_pend <= 1'b0;
`endif
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= addr;
                        lat_cnt <= '0;
                    end
                end
                FETCH: begin
                    state   <= WAIT;
                    lat_cnt <= lat_cnt + LAT_W'(1);
                end
                WAIT: begin
                    if (load) begin
                        state <= SHIFT;
`ifdef READ_CTRL_PREFETCH_EN
                        if (run) begin
                            rd_en   <= 1'b1;
                            rd_addr <= nxt;
                            lat_cnt <= '0;
                            bg_pend <= 1'b1;
                        end
`endif
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                SHIFT: begin
`ifdef READ_CTRL_PREFETCH_EN
                    if (shadow_load) begin
                        bg_pend <= 1'b0;
                    end else if (bg_pend) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
`endif
                    // Acting on the registered word_done puts the refetch one
                    // cycle after the last handshake.
                    if (word_done) begin
                        addr <= nxt;
`ifdef READ_CTRL_PREFETCH_EN
                        if (chained) begin
                            if (run) begin
                                rd_en   <= 1'b1;
                                rd_addr <= nxt2;
                                lat_cnt <= '0;
                                bg_pend <= 1'b1;
                            end
                        end else if (run) begin
`else
                        if (run) begin
`endif
                            state   <= FETCH;
                            rd_en   <= 1'b1;
                            rd_addr <= nxt;
                            lat_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_controller.sv
// Self-checking bench for read_controller: RAM model with fixed latency,
// byte-stream scoreboard over consumed words, randomized backpressure.
module tb_read_controller;

    import read_controller_pkg::*;

    localparam int unsigned LEN = 4;
    localparam int unsigned LAT = 3;
    localparam int unsigned NB  = DATA_W / BYTE_W;
`ifdef READ_CTRL_PREFETCH_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = LAT + 2;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [BYTE_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              word_done;
    logic              busy;

    always #5 clk = ~clk;

    read_controller #(
        .S1_LENGTH  (LEN),
        .DATA_W     (DATA_W),
        .BYTE_W     (BYTE_W),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .word_done (word_done),
        .busy      (busy)
    );

    // RAM model: data for a read appears LAT cycles after its rd_en cycle.
    logic [DATA_W-1:0] mem [LEN];
    logic [ADDR_W-1:0] pa  [LAT];
    logic              pv  [LAT];

    always @(posedge clk) begin
        pa[0] <= rd_addr;
        pv[0] <= rd_en;
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
    end

    assign rd_data = pv[LAT-1] ? mem[pa[LAT-1][1:0]] : {(DATA_W/32){32'hDEADBEEF}};

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state: word/byte the consumer should see next.
    int unsigned       exp_addr;
    int unsigned       exp_byte;
    int unsigned       words_done = 0;
    int unsigned       wd_count   = 0;
    logic [ADDR_W-1:0] rd_log [$];
    logic              prev_stall;
    logic [BYTE_W-1:0] prev_data;
    bit                gap_armed;
    int                gap_cnt;
    int                last_gap;

    function automatic logic [BYTE_W-1:0] ref_byte(input int unsigned a, input int unsigned k);
        logic [DATA_W-1:0] w;
        w = mem[a] >> (BYTE_W * (NB - 1 - k));
        return w[BYTE_W-1:0];
    endfunction

    task automatic model_reset();
        exp_addr   = 0;
        exp_byte   = 0;
        prev_stall = 1'b0;
        gap_armed  = 1'b0;
        last_gap   = -1;
    endtask

    // One clock: score the handshake of the current cycle, then check the next.
    task automatic cycle();
        logic last;
        last = 1'b0;
        if (m_valid && m_ready) begin
            check("byte", 64'(m_data), 64'(ref_byte(exp_addr, exp_byte)));
            if (exp_byte == NB - 1) begin
                last      = 1'b1;
                exp_byte  = 0;
                exp_addr  = (exp_addr + 1) % LEN;
                words_done++;
                gap_armed = 1'b1;
                gap_cnt   = 0;
            end else begin
                exp_byte++;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        @(posedge clk);
        #1;
        check("word_done", 64'(word_done), 64'(last));
        if (word_done) wd_count++;
        if (prev_stall) begin
            check("hold_valid", 64'(m_valid), 64'd1);
            check("hold_data", 64'(m_data), 64'(prev_data));
        end
        if (rd_en) begin
            rd_log.push_back(rd_addr);
            check("rd_addr", 64'(rd_addr), m_valid ? 64'((exp_addr + 1) % LEN) : 64'(exp_addr));
        end
        if (gap_armed) begin
            if (m_valid) begin
                last_gap  = gap_cnt;
                gap_armed = 1'b0;
            end else begin
                gap_cnt++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_m_data"}, 64'(m_data), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_word_done"}, 64'(word_done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned cnt;
        int unsigned i;
        int unsigned rd_mark;

        for (int a = 0; a < LEN; a++)
            for (int j = 0; j < DATA_W / 32; j++)
                mem[a][j*32 +: 32] = $urandom;
        for (int k = 0; k < NB; k++)
            mem[0][(NB - 1 - k) * BYTE_W +: BYTE_W] = BYTE_W'(k);

        // Reset held with run high: everything stays quiet.
        reset   = 1'b1;
        run     = 1'b1;
        m_ready = 1'b1;
        model_reset();
        repeat (4) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst");
        end
        reset = 1'b0;

        // Basic stream: one word, ready held high.
        cycle();
        check("start_rd_en", 64'(rd_en), 64'd1);
        check("start_rd_addr", 64'(rd_addr), 64'd0);
        run = 1'b0;
        cnt = 0;
        while (!m_valid && cnt < 50) begin
            cycle();
            cnt++;
        end
        check("first_valid_latency", 64'(cnt), 64'(LAT + 1));
        cnt = 0;
        while (words_done < 1 && cnt < 600) begin
            cycle();
            cnt++;
        end
        check("burst_cycles", 64'(cnt), 64'(NB));
        repeat (20) cycle();
        check("basic_busy_low", 64'(busy), 64'd0);
        check("basic_single_fetch", 64'(rd_log.size()), 64'd1);
        check("basic_wd_count", 64'(wd_count), 64'd1);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        run = 1'b1;
        cnt = 0;
        while (!rd_en && cnt < 10) begin
            cycle();
            cnt++;
        end
        check("bp_fetch_seen", 64'(rd_en), 64'd1);
        check("bp_rd_addr", 64'(rd_addr), 64'd1);
        run = 1'b0;
        i   = 0;
        cnt = 0;
        while (words_done < 2 && cnt < 3000) begin
            m_ready = (i % 4 == 0) || (i % 4 == 3);
            i++;
            cycle();
            cnt++;
        end
        check("bp_words", 64'(words_done), 64'd2);

        // run drops at byte 100: the word still completes, no new fetch.
        run = 1'b1;
        cnt = 0;
        while (!(exp_addr == 2 && exp_byte == 100) && cnt < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
            cnt++;
        end
        check("stop_reached_byte100", 64'(exp_byte), 64'd100);
        run     = 1'b0;
        rd_mark = rd_log.size();
        cnt     = 0;
        while (words_done < 3 && cnt < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
            cnt++;
        end
        m_ready = 1'b1;
        repeat (30) cycle();
        check("stop_words", 64'(words_done), 64'd3);
        check("stop_no_rd_en", 64'(rd_log.size()), 64'(rd_mark));
        check("stop_busy_low", 64'(busy), 64'd0);

        // Continuous run with random backpressure, then reset at byte 50.
        run = 1'b1;
        cnt = 0;
        while (!(words_done >= 5 && exp_byte == 50) && cnt < 8000) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
            cnt++;
        end
        check("reset_reached_byte50", 64'(exp_byte), 64'd50);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = 1'b1;
        rd_log.delete();

        // Wrap with run held high; also measures the inter-word gap.
        cnt = words_done;
        i   = 0;
        while (words_done < cnt + 6 && i < 5000) begin
            cycle();
            i++;
        end
        check("wrap_words", 64'(words_done), 64'(cnt + 6));
        check("wrap_fetch_count", 64'(rd_log.size() >= 6), 64'd1);
        for (int k = 0; k < 6; k++)
            if (k < rd_log.size())
                check("wrap_rd_addr_seq", 64'(rd_log[k]), 64'(k % LEN));
        check("gap_cycles", 64'(last_gap), 64'(EXP_GAP));
        check("wd_count_matches", 64'(wd_count), 64'(words_done));

        run = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cycle();
            cnt++;
        end
        check("final_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
